ps2_move_decoder: RTL and testbench
===================================

Name: ps2_move_decoder

Overview:
- Sits between the PS/2 keyboard controller and the game-logic handshake FSM.
- Converts raw set-2 scan-code bytes into directional and control commands, including make/break prefixes, extended prefixes and the Pause sequence.
- Holds commands in a small FIFO so that no keypress is lost while the FSM is busy drawing the maze, player box or screens.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries. Must be a power of 2, ≥2.
- ALLOW_REPEAT, 0: 1 = typematic repeats of a held key each enqueue a command; 0 = only the first make enqueues a command.
- PREFIX_TIMEOUT, 2500000: cycles (50 ms at 50 MHz) after which an unfinished prefix sequence is abandoned.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- ps2_key_data  in  8  received scan-code byte
- ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid on this cycle
- move_ready  in  1  consumer accepts the head command this cycle
- move_valid  out  1  FIFO non-empty
- move_dir  out  3  head command: 0 up, 1 down, 2 left, 3 right, 4 enter, 5 escape
- held_keys  out  6  bit i = key class i currently held (same encoding as move_dir)
- overflow  out  1  one-cycle pulse when a command is dropped because the FIFO is full

Behaviour:
- Reset, synchronous active-high:
  - Outputs: move_valid=0, move_dir=0, held_keys=0, overflow=0.
  - Internals: FIFO empty, parser in IDLE, timeout counter 0, skip counter 0.
  - Reset mid-sequence discards all partial state.
- Key map, set 2:
  - up: 1D (W), 75 (arrow or keypad 8).
  - down: 1B (S), 72.
  - left: 1C (A), 6B.
  - right: 23 (D), 74.
  - enter: 5A (with or without E0).
  - escape: 76.
  - All other codes are ignored, including E0 12 and E0 59 (fake shifts).
- Parser states: IDLE, EXT, BRK, EXT_BRK, SKIP. Transitions happen only on ps2_key_pressed.
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → SKIP with skip counter = 7.
    - FA, AA, EE, FE, 00, FF → ignored, stay IDLE.
    - Other → make event, stay IDLE.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay EXT.
    - Other → make event (E0 12 / E0 59 ignored), → IDLE.
  - BRK, EXT_BRK: any byte → break event, → IDLE.
  - SKIP: each byte decrements the counter; at 0 → IDLE. No events are produced.
- Timeout:
  - Counter runs in EXT, BRK, EXT_BRK and SKIP. It clears on every strobe and on entry to IDLE.
  - When it reaches PREFIX_TIMEOUT-1 → IDLE. No event is produced.
- Make event for mapped class k:
  - If held_keys[k]=1 and ALLOW_REPEAT=0: no command.
  - Otherwise enqueue k.
  - held_keys[k] is set in both cases, visible the next cycle.
- Break event for class k: clear held_keys[k]. Nothing is enqueued.
- Escape make:
  - Flushes all pending FIFO entries, then enqueues escape, so after the event the FIFO holds exactly one entry.
  - Flush takes priority over a same-cycle pop.
- FIFO:
  - Registered. move_valid and move_dir are driven from head storage.
  - A strobe at cycle N with an empty FIFO gives move_valid=1 at N+1.
  - Pop occurs when move_valid && move_ready. The next entry (or move_valid=0) appears on the following cycle.
  - Full and no pop: push is dropped, overflow=1 for one cycle.
  - Full with a same-cycle pop: push is accepted, occupancy unchanged.
  - Empty: move_ready is ignored.
- ps2_key_pressed is assumed single-cycle. Back-to-back strobes on consecutive cycles must each be processed.

Test Plan:
- Bytes 1D, then F0 1D; move_ready=1 → move_valid pulses 1 cycle with move_dir=0; held_keys[0] goes 1 then 0; FIFO ends empty.
- Bytes E0 74, E0 F0 74 → one command with move_dir=3; held_keys[3] toggles 1→0; no spurious command from F0 or 74 on the break.
- move_ready=0; send makes 1D, 1B, 1C, 23, 5A (releasing each) with FIFO_DEPTH=4 → four entries queued, overflow pulses once on the fifth; after raising move_ready, dirs pop in order 0,1,2,3.
- ALLOW_REPEAT=0; 1C repeated 3 times with no break → exactly one left command. With ALLOW_REPEAT=1 → three left commands.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 75 → no commands and no held changes during Pause; a single up command follows.
- Queue holds 2 directions; send 76 → FIFO holds only escape (move_dir=5).
- Send E0 alone, wait PREFIX_TIMEOUT cycles, then 6B → left command, parsed as a fresh make.
- Assert reset mid-EXT_BRK → outputs zero; next byte 72 → down command.

Source files
------------

// File: rtl/ps2_move_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder_if : scan-code input strobe and command FIFO handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ps2_move_decoder_if;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       move_ready;
  logic       move_valid;
  logic [2:0] move_dir;
  logic [5:0] held_keys;
  logic       overflow;

  modport master (
    output ps2_key_data, ps2_key_pressed, move_ready,
    input  move_valid, move_dir, held_keys, overflow
  );

  modport slave (
    input  ps2_key_data, ps2_key_pressed, move_ready,
    output move_valid, move_dir, held_keys, overflow
  );
endinterface

`default_nettype wire

// File: rtl/ps2_move_decoder.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder : set-2 scan codes -> direction/control commands in a FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_move_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int ALLOW_REPEAT   = 0,
  parameter int PREFIX_TIMEOUT = 2500000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  ps2_move_decoder_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [2:0]    CLS_ESC = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      skip_cnt, skip_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic            make_evt, brk_evt;

  logic [5:0]      held;
  logic [2:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            ovf;

  logic            key_ok;
  logic [2:0]      key_cls;
  logic            full, pop, push_req, push_cmd, push_esc, push_ok;

  function automatic logic [3:0] decode(input logic [7:0] b);
    case (b)
      8'h1D, 8'h75: decode = 4'b1_000;
      8'h1B, 8'h72: decode = 4'b1_001;
      8'h1C, 8'h6B: decode = 4'b1_010;
      8'h23, 8'h74: decode = 4'b1_011;
      8'h5A:        decode = 4'b1_100;
      8'h76:        decode = 4'b1_101;
      default:      decode = 4'b0_000;
    endcase
  endfunction

  assign {key_ok, key_cls} = decode(bus.ps2_key_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
      tmr      <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      tmr      <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    tmr_nxt   = tmr;
    make_evt  = 1'b0;
    brk_evt   = 1'b0;
    if (bus.ps2_key_pressed) begin
      tmr_nxt = '0;
      case (state)
        IDLE: begin
          case (bus.ps2_key_data)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'hE1: begin
              state_nxt = SKIP;
              skip_nxt  = 3'd7;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nxt = IDLE;
            default: make_evt = 1'b1;
          endcase
        end
        EXT: begin
          case (bus.ps2_key_data)
            8'hF0: state_nxt = EXT_BRK;
            8'hE0: state_nxt = EXT;
            default: begin
              // Fake shifts (E0 12 / E0 59) decode as unmapped and fall away here.
              make_evt  = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        BRK, EXT_BRK: begin
          brk_evt   = 1'b1;
          state_nxt = IDLE;
        end
        SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tmr == TMAX) begin
        state_nxt = IDLE;
        skip_nxt  = '0;
        tmr_nxt   = '0;
      end else begin
        tmr_nxt = tmr + TW'(1);
      end
    end
  end

  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = (count != '0) && bus.move_ready;
  assign push_req = make_evt && key_ok && !(held[key_cls] && (ALLOW_REPEAT == 0));
  assign push_esc = push_req && (key_cls == CLS_ESC);
  assign push_cmd = push_req && (key_cls != CLS_ESC);
  assign push_ok  = push_cmd && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      held   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      ovf <= push_cmd && full && !pop;
      if (make_evt && key_ok) held[key_cls] <= 1'b1;
      if (brk_evt && key_ok)  held[key_cls] <= 1'b0;
      if (push_esc) begin
        // Escape discards everything pending, including a same-cycle pop.
        mem[wr_ptr] <= CLS_ESC;
        rd_ptr      <= wr_ptr;
        wr_ptr      <= wr_ptr + PW'(1);
        count       <= CW'(1);
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= key_cls;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push_ok && !pop)      count <= count + CW'(1);
        else if (!push_ok && pop) count <= count - CW'(1);
      end
    end
  end

  assign bus.move_valid = (count != '0);
  assign bus.move_dir   = mem[rd_ptr];
  assign bus.held_keys  = held;
  assign bus.overflow   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_ps2_move_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_move_decoder : directed + random bench against a queue-based model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ps2_move_decoder;
  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_move_decoder_if b0();
  ps2_move_decoder_if b1();

  ps2_move_decoder #(.FIFO_DEPTH(DEPTH), .ALLOW_REPEAT(0), .PREFIX_TIMEOUT(TMO))
    dut0 (.clk(clk), .reset(reset), .bus(b0));
  ps2_move_decoder #(.FIFO_DEPTH(DEPTH), .ALLOW_REPEAT(1), .PREFIX_TIMEOUT(TMO))
    dut1 (.clk(clk), .reset(reset), .bus(b1));

  int checks = 0;
  int errors = 0;

  // Reference model: prefix bytes kept as a list, commands as plain arrays.
  logic [7:0] pfx[$];
  int         mskip;
  int         mtmr;
  logic [5:0] mheld [2];
  logic [2:0] mfifo [2][DEPTH];
  int         mcnt  [2];
  bit         movf  [2];

  logic [2:0] got0[$], got1[$];
  int         ovf0;

  logic [7:0] pool [20] = '{8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C, 8'h6B, 8'h23, 8'h74,
                            8'h5A, 8'h76, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h12, 8'h59,
                            8'hFA, 8'h14, 8'h77, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] keymap(input logic [7:0] b);
    case (b)
      8'h1D, 8'h75: return {1'b1, 3'd0};
      8'h1B, 8'h72: return {1'b1, 3'd1};
      8'h1C, 8'h6B: return {1'b1, 3'd2};
      8'h23, 8'h74: return {1'b1, 3'd3};
      8'h5A:        return {1'b1, 3'd4};
      8'h76:        return {1'b1, 3'd5};
      default:      return 4'b0;
    endcase
  endfunction

  function automatic bit pfx_has(input logic [7:0] v);
    foreach (pfx[j]) if (pfx[j] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    pfx.delete();
    mskip = 0;
    mtmr  = 0;
    for (int i = 0; i < 2; i++) begin
      mheld[i] = '0;
      mcnt[i]  = 0;
      movf[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit s, input logic [7:0] d, input bit r);
    bit mk, bk, ok, supp, pop, push, esc;
    logic [2:0] cls;
    mk = 1'b0;
    bk = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (s) begin
      mtmr = 0;
      if (mskip > 0) mskip--;
      else if (pfx.size() == 0) begin
        if (d == 8'hE0 || d == 8'hF0) pfx.push_back(d);
        else if (d == 8'hE1) mskip = 7;
        else if (!(d inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) mk = 1'b1;
      end else if (pfx_has(8'hF0)) begin
        bk = 1'b1;
        pfx.delete();
      end else if (d == 8'hF0) pfx.push_back(d);
      else if (d != 8'hE0) begin
        mk = 1'b1;
        pfx.delete();
      end
    end else if (pfx.size() > 0 || mskip > 0) begin
      if (mtmr == TMO - 1) begin
        pfx.delete();
        mskip = 0;
        mtmr  = 0;
      end else mtmr++;
    end
    {ok, cls} = keymap(d);
    for (int i = 0; i < 2; i++) begin
      pop     = (mcnt[i] > 0) && r;
      movf[i] = 1'b0;
      supp    = mheld[i][cls] && (i == 0);
      push    = mk && ok && !supp && (cls != 3'd5);
      esc     = mk && ok && !supp && (cls == 3'd5);
      if (mk && ok) mheld[i][cls] = 1'b1;
      if (bk && ok) mheld[i][cls] = 1'b0;
      if (esc) begin
        mfifo[i][0] = 3'd5;
        mcnt[i]     = 1;
      end else begin
        if (push && mcnt[i] == DEPTH && !pop) begin
          movf[i] = 1'b1;
          push    = 1'b0;
        end
        if (pop) begin
          for (int j = 0; j < DEPTH - 1; j++) mfifo[i][j] = mfifo[i][j+1];
          mcnt[i]--;
        end
        if (push) begin
          mfifo[i][mcnt[i]] = cls;
          mcnt[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("valid0", b0.move_valid, mcnt[0] > 0);
    chk("held0", b0.held_keys, mheld[0]);
    chk("ovf0", b0.overflow, movf[0]);
    if (mcnt[0] > 0) chk("dir0", b0.move_dir, mfifo[0][0]);
    chk("valid1", b1.move_valid, mcnt[1] > 0);
    chk("held1", b1.held_keys, mheld[1]);
    chk("ovf1", b1.overflow, movf[1]);
    if (mcnt[1] > 0) chk("dir1", b1.move_dir, mfifo[1][0]);
    if (b0.overflow === 1'b1) ovf0++;
  endtask

  task automatic tick(input bit s, input logic [7:0] d, input bit r);
    b0.ps2_key_pressed = s;  b1.ps2_key_pressed = s;
    b0.ps2_key_data    = d;  b1.ps2_key_data    = d;
    b0.move_ready      = r;  b1.move_ready      = r;
    if (b0.move_valid === 1'b1 && r) got0.push_back(b0.move_dir);
    if (b1.move_valid === 1'b1 && r) got1.push_back(b1.move_dir);
    @(posedge clk);
    model_step(s, d, r);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] d, input bit r);
    tick(1'b1, d, r);
    tick(1'b0, 8'h00, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    chk("rst_dir0", b0.move_dir, 3'd0);
    chk("rst_dir1", b1.move_dir, 3'd0);
  endtask

  function automatic logic [31:0] at(input int idx, input int which);
    if (which == 0) return (idx < got0.size()) ? 32'(got0[idx]) : 32'hDEAD;
    return (idx < got1.size()) ? 32'(got1[idx]) : 32'hDEAD;
  endfunction

  initial begin
    b0.ps2_key_pressed = 1'b0; b1.ps2_key_pressed = 1'b0;
    b0.ps2_key_data    = 8'h00; b1.ps2_key_data   = 8'h00;
    b0.move_ready      = 1'b0; b1.move_ready      = 1'b0;
    model_reset();
    do_reset();
    do_reset();

    // W make then break
    got0.delete();
    send(8'h1D, 1'b1); send(8'hF0, 1'b1); send(8'h1D, 1'b1); idle(2, 1'b1);
    chk("w_count", got0.size(), 1);
    chk("w_dir", at(0, 0), 0);

    // extended right arrow
    got0.delete();
    send(8'hE0, 1'b1); send(8'h74, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h74, 1'b1); idle(2, 1'b1);
    chk("ext_count", got0.size(), 1);
    chk("ext_dir", at(0, 0), 3);

    // fill FIFO and overflow on the fifth command
    got0.delete();
    ovf0 = 0;
    foreach (pool[k]) if (k < 5) begin
      send(pool[2*k], 1'b0); send(8'hF0, 1'b0); send(pool[2*k], 1'b0);
    end
    chk("ovf_pulses", ovf0, 1);
    idle(6, 1'b1);
    chk("fill_count", got0.size(), 4);
    for (int k = 0; k < 4; k++) chk("fill_order", at(k, 0), k);

    // typematic repeat
    got0.delete(); got1.delete();
    send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1); idle(3, 1'b1);
    chk("rep0_count", got0.size(), 1);
    chk("rep1_count", got1.size(), 3);

    // Pause sequence followed by up
    got0.delete();
    send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
    send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
    chk("pause_held", b0.held_keys, 6'd0);
    send(8'h75, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1); idle(2, 1'b1);
    chk("pause_count", got0.size(), 1);
    chk("pause_dir", at(0, 0), 0);

    // escape flushes pending directions
    got0.delete();
    send(8'h1D, 1'b0); send(8'hF0, 1'b0); send(8'h1D, 1'b0);
    send(8'h1B, 1'b0); send(8'hF0, 1'b0); send(8'h1B, 1'b0);
    send(8'h76, 1'b0);
    send(8'hF0, 1'b1); send(8'h76, 1'b1); idle(3, 1'b1);
    chk("esc_count", got0.size(), 1);
    chk("esc_dir", at(0, 0), 5);

    // abandoned E0 prefix
    got0.delete();
    tick(1'b1, 8'hE0, 1'b1);
    idle(TMO, 1'b1);
    send(8'h6B, 1'b1); send(8'hF0, 1'b1); send(8'h6B, 1'b1); idle(2, 1'b1);
    chk("tmo_count", got0.size(), 1);
    chk("tmo_dir", at(0, 0), 2);

    // reset in the middle of E0 F0
    got0.delete();
    send(8'hE0, 1'b1); send(8'hF0, 1'b1);
    do_reset();
    send(8'h72, 1'b1); send(8'hF0, 1'b1); send(8'h72, 1'b1); idle(2, 1'b1);
    chk("rstmid_count", got0.size(), 1);
    chk("rstmid_dir", at(0, 0), 1);

    // randomized traffic, including back-to-back strobes and timeouts
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 250) == 0) idle(TMO + $urandom_range(0, 3) - 2, $urandom_range(0, 1) == 1);
      else tick($urandom_range(0, 2) == 0, pool[$urandom_range(0, 19)], $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
